// File: rtl/lcd_pkg.sv
// Shared FSM state encoding and cycle-count helpers for the LCD SPI link.
package lcd_pkg;

  // Link controller states; the encoding is also visible on the debug port.
  typedef enum logic [2:0] {
    RST_LOW   = 3'd0,
    BOOT_WAIT = 3'd1,
    IDLE      = 3'd2,
    SHIFT     = 3'd3,
    HOLD      = 3'd4,
    GAP       = 3'd5
  } lcd_state_e;

  // Microsecond delay expressed in system clock cycles.
  function automatic int unsigned us_to_cycles(input int unsigned mhz, input int unsigned us);
    return mhz * us;
  endfunction

  // Terminal counter value for an n-cycle delay; a zero delay still spends one cycle.
  function automatic int unsigned last_index(input int unsigned n);
    return (n == 0) ? 0 : n - 1;
  endfunction

  // Largest of three counts, never below 1 so counter widths stay positive.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = 1;
    if (a > m) m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/lcd_spi_shifter.sv
// Mode-0 MSB-first word shifter: owns the shift register and the LCD_CLK phase timing.
module lcd_spi_shifter #(
  parameter int unsigned SCLK_DIV  = 2,
  parameter int unsigned WORD_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [WORD_BITS-1:0] data_i,
  output logic                 sclk_o,
  output logic                 mosi_o,
  output logic                 done_o,
  output logic                 last_bit_o
);

  localparam int unsigned DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(WORD_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_BITS - 1);

  logic                 busy_q, busy_d;
  logic                 phase_q, phase_d;   // 0 = low half-period, 1 = high half-period
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [WORD_BITS-1:0] shreg_q, shreg_d;
  logic                 phase_end;

  assign phase_end  = busy_q && (div_q == DIV_LAST);
  assign last_bit_o = (bit_q == BIT_LAST);
  // done marks the final cycle of a bit's high phase.
  assign done_o     = phase_end && phase_q;
  assign sclk_o     = phase_q;
  assign mosi_o     = shreg_q[WORD_BITS-1];

  // Phase/bit sequencing; data shifts only when the clock falls into the next bit.
  always_comb begin
    busy_d  = busy_q;
    phase_d = phase_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    if (start_i) begin
      busy_d  = 1'b1;
      phase_d = 1'b0;
      div_d   = '0;
      bit_d   = '0;
      shreg_d = data_i;
    end else if (busy_q) begin
      if (phase_end) begin
        div_d = '0;
        if (!phase_q) begin
          phase_d = 1'b1;
        end else if (last_bit_o) begin
          busy_d  = 1'b0;
          phase_d = 1'b0;
        end else begin
          phase_d = 1'b0;
          bit_d   = bit_q + 1'b1;
          shreg_d = {shreg_q[WORD_BITS-2:0], 1'b0};
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // Shifter state registers, cleared asynchronously so LCD_CLK and MOSI drop at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q  <= 1'b0;
      phase_q <= 1'b0;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      busy_q  <= busy_d;
      phase_q <= phase_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/lcd_spi_link.sv
// LCD panel link: panel reset/boot sequencing plus framed SPI word transmission.
//
// Handshake: a word transfers on a rising edge where TX_VALID=1 and TX_READY=1.
// TX_READY is high only in IDLE or HOLD while REINIT is low; it never depends
// on TX_VALID. TX_DATA/TX_DC/TX_LAST are sampled on that same edge.
module lcd_spi_link
  import lcd_pkg::*;
#(
  parameter int unsigned CLOCK_SPEED_MHZ = 12,
  parameter int unsigned SCLK_DIV        = 2,
  parameter int unsigned WORD_BITS       = 8,
  parameter int unsigned RESET_US        = 10000,
  parameter int unsigned BOOT_US         = 120000,
  parameter int unsigned CS_GAP          = 2
) (
  input  logic                 SYSTEM_CLK,
  input  logic                 RST_N,
  input  logic                 REINIT,
  input  logic                 TX_VALID,
  output logic                 TX_READY,
  input  logic [WORD_BITS-1:0] TX_DATA,
  input  logic                 TX_DC,
  input  logic                 TX_LAST,
  output logic                 INIT_DONE,
  output logic                 CS,
  output logic                 MOSI,
  output logic                 DC,
  output logic                 LCD_CLK,
  output logic                 RESET,
  output logic [2:0]           STATE_DBG
);

  localparam int unsigned RST_CYC  = us_to_cycles(CLOCK_SPEED_MHZ, RESET_US);
  localparam int unsigned BOOT_CYC = us_to_cycles(CLOCK_SPEED_MHZ, BOOT_US);
  localparam int unsigned GAP_CYC  = CS_GAP * SCLK_DIV;
  localparam int unsigned CNT_W    = $clog2(max3(RST_CYC, BOOT_CYC, GAP_CYC) + 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(last_index(RST_CYC));
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(last_index(BOOT_CYC));
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(last_index(GAP_CYC));

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dc_q, dc_d;
  logic             last_q, last_d;
  logic             init_q, init_d;
  logic             sh_start, sh_done, sh_last;

  lcd_spi_shifter #(
    .SCLK_DIV  (SCLK_DIV),
    .WORD_BITS (WORD_BITS)
  ) u_shifter (
    .clk_i      (SYSTEM_CLK),
    .rst_ni     (RST_N),
    .start_i    (sh_start),
    .data_i     (TX_DATA),
    .sclk_o     (LCD_CLK),
    .mosi_o     (MOSI),
    .done_o     (sh_done),
    .last_bit_o (sh_last)
  );

  assign TX_READY  = ((state_q == IDLE) || (state_q == HOLD)) && !REINIT;
  assign CS        = !((state_q == SHIFT) || (state_q == HOLD));
  assign RESET     = (state_q != RST_LOW);
  assign DC        = dc_q;
  assign INIT_DONE = init_q;
  assign STATE_DBG = state_q;

  // Next-state logic: delay counting, word acceptance and frame termination.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dc_d     = dc_q;
    last_d   = last_q;
    init_d   = init_q;
    sh_start = 1'b0;
    case (state_q)
      RST_LOW: begin
        if (cnt_q == RST_LAST) begin
          state_d = BOOT_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BOOT_WAIT: begin
        if (cnt_q == BOOT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          init_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE, HOLD: begin
        // REINIT outranks a pending word.
        if (REINIT) begin
          state_d = RST_LOW;
          cnt_d   = '0;
          init_d  = 1'b0;
        end else if (TX_VALID) begin
          state_d  = SHIFT;
          sh_start = 1'b1;
          dc_d     = TX_DC;
          last_d   = TX_LAST;
        end
      end
      SHIFT: begin
        if (sh_done && sh_last) begin
          state_d = last_q ? GAP : HOLD;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Controller registers; reset restarts the panel reset sequence.
  always_ff @(posedge SYSTEM_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= RST_LOW;
      cnt_q   <= '0;
      dc_q    <= 1'b0;
      last_q  <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dc_q    <= dc_d;
      last_q  <= last_d;
      init_q  <= init_d;
    end
  end

endmodule

// File: tb/tb_lcd_spi_link.sv
// Bench for lcd_spi_link: boot timing, framed words, HOLD chaining, REINIT and async reset.
module tb_lcd_spi_link;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         reinit = 1'b0;
  logic         tx_valid = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_dc = 1'b0;
  logic         tx_last = 1'b0;
  logic         tx_ready, init_done, cs, mosi, dc, lcd_clk, reset_pin;
  logic [2:0]   state_dbg;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_spi_link #(
    .CLOCK_SPEED_MHZ (12),
    .SCLK_DIV        (1),
    .WORD_BITS       (W),
    .RESET_US        (1),
    .BOOT_US         (2),
    .CS_GAP          (2)
  ) dut (
    .SYSTEM_CLK (clk),
    .RST_N      (rst_n),
    .REINIT     (reinit),
    .TX_VALID   (tx_valid),
    .TX_READY   (tx_ready),
    .TX_DATA    (tx_data),
    .TX_DC      (tx_dc),
    .TX_LAST    (tx_last),
    .INIT_DONE  (init_done),
    .CS         (cs),
    .MOSI       (mosi),
    .DC         (dc),
    .LCD_CLK    (lcd_clk),
    .RESET      (reset_pin),
    .STATE_DBG  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [W:0] exp_q[$];   // {dc, data} in acceptance order
  int start_q[$];         // cycle of each word's first LCD_CLK rise

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Wire monitor: rebuild words from LCD_CLK rises while CS is low.
  int         bit_n = 0;
  int         cs_rise = 0;
  int         mosi_bad = 0;
  logic       prev_clk = 1'b0, prev_cs = 1'b1, prev_mosi = 1'b0;
  logic       first_dc = 1'b0, dc_ok = 1'b1;
  logic [W-1:0] sh = '0;
  logic [W:0]   got_w, exp_w;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bit_n = 0;
        prev_clk = 1'b0;
        prev_cs = 1'b1;
        prev_mosi = 1'b0;
      end else begin
        if (cs && !prev_cs) cs_rise++;
        if (!cs && !prev_cs && bit_n > 0 && mosi !== prev_mosi && !(prev_clk && !lcd_clk))
          mosi_bad++;
        if (cs) begin
          bit_n = 0;
        end else if (lcd_clk && !prev_clk) begin
          if (bit_n == 0) begin
            first_dc = dc;
            dc_ok = 1'b1;
            start_q.push_back(cyc);
          end else if (dc !== first_dc) begin
            dc_ok = 1'b0;
          end
          sh = {sh[W-2:0], mosi};
          bit_n++;
          if (bit_n == W) begin
            bit_n = 0;
            got_w = {first_dc, sh};
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_word: got 0x%0h expected none", got_w);
            end else begin
              exp_w = exp_q.pop_front();
              check("wire_word", got_w, exp_w);
              check("dc_stable", dc_ok, 1);
            end
          end
        end
        prev_clk = lcd_clk;
        prev_cs = cs;
        prev_mosi = mosi;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Offer one word and wait for the handshake; returns in the first SHIFT cycle.
  task automatic send_word(input logic [W-1:0] d, input logic d_c, input logic l,
                           input logic [W:0] exp);
    int k;
    tx_data = d;
    tx_dc = d_c;
    tx_last = l;
    tx_valid = 1'b1;
    k = 0;
    while (tx_ready !== 1'b1 && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    check("handshake", tx_ready, 1);
    if (tx_ready === 1'b1) exp_q.push_back(exp);
    @(negedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (tx_ready !== 1'b1 && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    check("idle_reached", tx_ready, 1);
  endtask

  // Starts on the first RESET-low cycle; measures reset and boot lengths.
  task automatic count_boot(input string tag, output int ready_seen, output int cs_low_seen);
    int n;
    int m;
    ready_seen = 0;
    cs_low_seen = 0;
    n = 0;
    while (reset_pin !== 1'b1 && n < 100) begin
      n++;
      if (tx_ready) ready_seen++;
      if (!cs) cs_low_seen++;
      @(negedge clk); #1;
    end
    check({tag, "_reset_low_cycles"}, n, 12);
    m = 0;
    while (init_done !== 1'b1 && m < 200) begin
      m++;
      if (tx_ready) ready_seen++;
      if (!cs) cs_low_seen++;
      @(negedge clk); #1;
    end
    check({tag, "_boot_cycles"}, m, 24);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [W-1:0] data;
    logic         dc;
    logic [W:0]   exp_wire;
    int           exp_cs_low;
    int           exp_gap;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int rs, cl, c, g, r0, s0;
    logic [W-1:0] rnd;
    logic         rdc;

    rnd = 8'($urandom_range(0, 255));
    rdc = 1'($urandom_range(0, 1));
    vecs[0] = '{8'hA5, 1'b1, 9'h1A5, 16, 2};
    vecs[1] = '{8'h00, 1'b0, 9'h000, 16, 2};
    vecs[2] = '{8'hFF, 1'b1, 9'h1FF, 16, 2};
    vecs[3] = '{8'h81, 1'b0, 9'h081, 16, 2};
    vecs[4] = '{8'h3C, 1'b1, 9'h13C, 16, 2};
    vecs[5] = '{rnd,   rdc,  {rdc, rnd}, 16, 2};

    // Reset values while RST_N is held low.
    repeat (3) @(negedge clk);
    #1;
    check("rst_cs", cs, 1);
    check("rst_lcd_clk", lcd_clk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_dc", dc, 0);
    check("rst_reset_pin", reset_pin, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_init_done", init_done, 0);

    // Boot with TX_VALID held: no handshake until the first INIT_DONE cycle.
    tx_data = 8'h5A;
    tx_dc = 1'b0;
    tx_last = 1'b1;
    tx_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    count_boot("boot", rs, cl);
    check("boot_no_ready", rs, 0);
    check("boot_cs_high", cl, 0);
    check("first_accept_on_init", tx_ready, 1);
    if (tx_ready === 1'b1) exp_q.push_back(9'h05A);
    @(negedge clk); #1;
    tx_valid = 1'b0;
    wait_idle();

    // Single-word frames: CS low for the word, then the CS gap before ready.
    for (int i = 0; i < 6; i++) begin
      send_word(vecs[i].data, vecs[i].dc, 1'b1, vecs[i].exp_wire);
      c = 0;
      while (cs === 1'b0 && c < 100) begin
        c++;
        @(negedge clk); #1;
      end
      check("cs_low_cycles", c, vecs[i].exp_cs_low);
      g = 0;
      while (tx_ready !== 1'b1 && g < 100) begin
        g++;
        @(negedge clk); #1;
      end
      check("cs_gap_cycles", g, vecs[i].exp_gap);
    end

    // Two-word frame chained through HOLD.
    r0 = cs_rise;
    s0 = start_q.size();
    send_word(8'h2C, 1'b0, 1'b0, 9'h02C);
    send_word(8'hFF, 1'b1, 1'b1, 9'h1FF);
    wait_idle();
    check("frame_cs_rises", cs_rise - r0, 1);
    check("frame_word_count", start_q.size() - s0, 2);
    if (start_q.size() >= s0 + 2)
      check("back_to_back_spacing", start_q[s0 + 1] - start_q[s0], 17);

    // REINIT during SHIFT is ignored.
    send_word(8'h96, 1'b0, 1'b1, 9'h096);
    reinit = 1'b1;
    #1;
    check("shift_reinit_no_ready", tx_ready, 0);
    @(negedge clk); #1;
    reinit = 1'b0;
    check("shift_reinit_cs", cs, 0);
    check("shift_reinit_reset_pin", reset_pin, 1);
    wait_idle();
    check("shift_reinit_init_done", init_done, 1);

    // REINIT with TX_VALID in HOLD: reinit wins, panel reset reruns.
    send_word(8'h11, 1'b0, 1'b0, 9'h011);
    repeat (16) @(negedge clk);
    #1;
    check("hold_cs", cs, 0);
    check("hold_lcd_clk", lcd_clk, 0);
    tx_data = 8'hEE;
    tx_dc = 1'b1;
    tx_last = 1'b1;
    tx_valid = 1'b1;
    reinit = 1'b1;
    #1;
    check("hold_reinit_no_ready", tx_ready, 0);
    @(negedge clk);
    reinit = 1'b0;
    tx_valid = 1'b0;
    #1;
    check("reinit_cs", cs, 1);
    check("reinit_init_done", init_done, 0);
    count_boot("reinit", rs, cl);
    check("reinit_cs_high", cl, 0);
    send_word(8'h42, 1'b1, 1'b1, 9'h142);
    wait_idle();

    // Async reset in the middle of bit 3.
    send_word(8'h3C, 1'b1, 1'b1, 9'h13C);
    repeat (7) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_cs", cs, 1);
    check("async_lcd_clk", lcd_clk, 0);
    check("async_mosi", mosi, 0);
    check("async_reset_pin", reset_pin, 0);
    check("async_init_done", init_done, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    count_boot("rerst", rs, cl);
    send_word(8'hC3, 1'b0, 1'b1, 9'h0C3);
    wait_idle();

    // Final report.
    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("mosi_only_on_fall", mosi_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_spi_link.md
LCD_SPI_LINK -- requirements
Module: lcd_spi_link

Interface
REQ-001 SHALL have parameter CLOCK_SPEED_MHZ, default 12: SYSTEM_CLK frequency in MHz.
REQ-002 SHALL have parameter SCLK_DIV, default 2, legal >= 1: SYSTEM_CLK cycles per LCD_CLK half-period.
REQ-003 SHALL have parameter WORD_BITS, default 8, legal 8..16: bits per transferred word.
REQ-004 SHALL have parameter RESET_US, default 10000: panel RESET low time in microseconds.
REQ-005 SHALL have parameter BOOT_US, default 120000: wait after RESET release before the first transfer, in microseconds.
REQ-006 SHALL have parameter CS_GAP, default 2: LCD_CLK half-periods with CS high after a frame ends.
REQ-007 SHALL have port SYSTEM_CLK  in  1  sole clock, all logic on rising edge.
REQ-008 SHALL have port RST_N  in  1  asynchronous active-low reset.
REQ-009 SHALL have port REINIT  in  1  single-cycle request to rerun the panel reset sequence.
REQ-010 SHALL have ports TX_VALID in 1, TX_READY out 1: word handshake.
REQ-011 SHALL have ports TX_DATA in WORD_BITS, TX_DC in 1, TX_LAST in 1: word, DC level for the word, end-of-frame flag.
REQ-012 SHALL have port INIT_DONE  out  1  high once the boot wait completes.
REQ-013 SHALL have ports CS, MOSI, DC, LCD_CLK, RESET  out  1 each: panel pins.

Function
REQ-014 SHALL implement states RST_LOW, BOOT_WAIT, IDLE, SHIFT, HOLD, GAP.
REQ-015 RST_LOW SHALL drive RESET=0 for CLOCK_SPEED_MHZ*RESET_US cycles, then go to BOOT_WAIT with RESET=1.
REQ-016 BOOT_WAIT SHALL last CLOCK_SPEED_MHZ*BOOT_US cycles, then go to IDLE and set INIT_DONE=1.
REQ-017 TX_READY SHALL be 1 only in IDLE or HOLD with REINIT=0.
REQ-018 A word SHALL be accepted on a cycle with TX_VALID=1 and TX_READY=1; TX_DATA, TX_DC and TX_LAST are captured on that cycle.
REQ-019 On the cycle after acceptance, the block SHALL drive CS=0, DC=captured TX_DC and MOSI=MSB, and enter SHIFT.
REQ-020 SHIFT SHALL use SPI mode 0, MSB first: LCD_CLK low for SCLK_DIV cycles, then high for SCLK_DIV cycles, per bit; MOSI changes only when LCD_CLK falls.
REQ-021 A word SHALL occupy exactly 2*SCLK_DIV*WORD_BITS cycles.
REQ-022 After the last bit, the block SHALL go to HOLD if TX_LAST=0 (CS stays 0, LCD_CLK=0), or to GAP if TX_LAST=1.
REQ-023 GAP SHALL drive CS=1 for CS_GAP*SCLK_DIV cycles, then go to IDLE.
REQ-024 A word accepted in HOLD SHALL start with no CS toggle; back-to-back words SHALL have zero idle cycles between the last LCD_CLK high and the next first bit low phase, beyond the acceptance cycle.
REQ-025 REINIT SHALL be honoured only in IDLE or HOLD and ignored in other states.
REQ-026 When honoured, REINIT SHALL force CS=1, clear INIT_DONE and enter RST_LOW.
REQ-027 REINIT SHALL win over a simultaneous TX_VALID.
REQ-028 TX_VALID during RST_LOW or BOOT_WAIT SHALL be ignored, with no handshake.
REQ-029 Delay counters SHALL be sized as $clog2 of the largest count plus 1, and SHALL never wrap.

Reset
REQ-030 RST_N=0 SHALL asynchronously force RST_LOW with CS=1, LCD_CLK=0, MOSI=0, DC=0, RESET=0, TX_READY=0, INIT_DONE=0, and all counters cleared.
REQ-031 Reset mid-transfer SHALL abort the word; CS SHALL go high immediately and the boot sequence SHALL restart on release.

Structure
REQ-032 Package lcd_pkg SHALL hold the state enum and the derived cycle-count constants.
REQ-033 Shift register and LCD_CLK phase counter SHALL be sub-module lcd_spi_shifter, which has start, done and last-bit signals.

Verification (CLOCK_SPEED_MHZ=12, RESET_US=1, BOOT_US=2, SCLK_DIV=1, WORD_BITS=8, CS_GAP=2)
REQ-034 Release RST_N -> RESET low 12 cycles, then INIT_DONE=1 exactly 24 cycles after RESET rises.
REQ-035 Send TX_DATA=0xA5, DC=1, LAST=1 -> 8 LCD_CLK rising edges sample 1,0,1,0,0,1,0,1; CS low 16 cycles, then high for 2 cycles before TX_READY returns.
REQ-036 Send 0x2C (DC=0, LAST=0), then 0xFF (DC=1, LAST=1) -> CS stays low across both words; DC changes only at the start of the second word.
REQ-037 Hold TX_VALID=1 during BOOT_WAIT -> no handshake and CS stays high; first acceptance happens on the cycle INIT_DONE rises.
REQ-038 Pulse REINIT together with TX_VALID in HOLD -> word not accepted, CS=1 next cycle, RESET low 12 cycles, INIT_DONE=0.
REQ-039 Assert RST_N=0 at bit 3 of a word -> CS=1 and LCD_CLK=0 without waiting for a clock edge; a full boot sequence follows release.
